// File: rtl/ozer_alican_pr4.sv
// ozer_alican_pr4: single-cycle 32-bit MIPS-subset processor.
// Every rising edge retires one instruction: fetch, decode, execute,
// memory access and write-back all happen combinationally within a cycle.
// Optional build macro JAL_JR_EN adds jal (op 0x03) and jr (funct 0x08);
// without it both encodings fall through to the unknown-instruction NOP path.

// Three-port register file: two asynchronous reads, one synchronous write.
module RegFile (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  rsAddr,
  input  logic [4:0]  rtAddr,
  input  logic [4:0]  wAddr,
  input  logic [31:0] wData,
  output logic [31:0] rsData,
  output logic [31:0] rtData
);

  logic [31:0] rMem [0:31];

  // Write port; anything aimed at r0 is dropped.
  always_ff @(posedge clock) begin
    if (we && (wAddr != 5'd0)) begin
      rMem[wAddr] <= wData;
    end
  end

  // Read ports see the pre-edge contents; r0 is forced to zero on read.
  always_comb begin
    rsData = (rsAddr == 5'd0) ? 32'd0 : rMem[rsAddr];
    rtData = (rtAddr == 5'd0) ? 32'd0 : rMem[rtAddr];
  end

endmodule

// Instruction memory: combinational fetch, with a write port the core ties off.
module InstrMem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wData,
  output logic [31:0]   rData
);

  logic [31:0] iMem [0:WORDS-1];

  // Optional load path; the core never asserts it, contents come from outside.
  always_ff @(posedge clock) begin
    if (we) begin
      iMem[addr] <= wData;
    end
  end

  // Fetch is a plain combinational array lookup.
  always_comb begin
    rData = iMem[addr];
  end

endmodule

// Data memory: word-addressed, asynchronous read, synchronous write.
module DataMem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wData,
  output logic [31:0]   rData
);

  logic [31:0] dMem [0:WORDS-1];

  // Store port, committed on the rising edge.
  always_ff @(posedge clock) begin
    if (we) begin
      dMem[addr] <= wData;
    end
  end

  // Load data is available in the same cycle the address is formed.
  always_comb begin
    rData = dMem[addr];
  end

endmodule

// Core top level.
module ozer_alican_pr4 #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] result
);

  localparam int          IAW     = $clog2(IMEM_WORDS);
  localparam int          DAW     = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

`ifdef JAL_JR_EN
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
`endif

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;
  logic [31:0] instr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] immSext;
  logic [31:0] immZext;

  logic [31:0] rsVal;
  logic [31:0] rtVal;
  logic [31:0] aluOut;
  logic [31:0] memAddr;
  logic [31:0] memRData;
  logic [31:0] regWData;
  logic [4:0]  regWAddr;
  logic        regWe;
  logic        memWe;
  logic        isLoad;

  // Instruction field split and immediate extension.
  always_comb begin
    opcode  = instr[31:26];
    rs      = instr[25:21];
    rt      = instr[20:16];
    rd      = instr[15:11];
    shamt   = instr[10:6];
    funct   = instr[5:0];
    imm     = instr[15:0];
    target  = instr[25:0];
    immSext = {{16{instr[15]}}, instr[15:0]};
    immZext = {16'd0, instr[15:0]};
    pcPlus4 = pc + 32'd4;
    memAddr = rsVal + immSext;
  end

  InstrMem #(
    .WORDS (IMEM_WORDS)
  ) imModul (
    .clock (clock),
    .we    (1'b0),
    .addr  (pc[IAW+1:2]),
    .wData (32'd0),
    .rData (instr)
  );

  // Writes are held off while reset is asserted so preloaded state is untouched.
  RegFile regMod (
    .clock  (clock),
    .we     (regWe && !reset),
    .rsAddr (rs),
    .rtAddr (rt),
    .wAddr  (regWAddr),
    .wData  (regWData),
    .rsData (rsVal),
    .rtData (rtVal)
  );

  DataMem #(
    .WORDS (DMEM_WORDS)
  ) datamem (
    .clock (clock),
    .we    (memWe && !reset),
    .addr  (memAddr[DAW+1:2]),
    .wData (rtVal),
    .rData (memRData)
  );

  // Main decode/execute: ALU result, write-back controls and next PC.
  always_comb begin
    aluOut   = 32'd0;
    regWe    = 1'b0;
    regWAddr = 5'd0;
    memWe    = 1'b0;
    isLoad   = 1'b0;
    nextPc   = pcPlus4;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            aluOut   = rsVal + rtVal;
            regWe    = 1'b1;
            regWAddr = rd;
          end
          FN_SUB: begin
            aluOut   = rsVal - rtVal;
            regWe    = 1'b1;
            regWAddr = rd;
          end
          FN_AND: begin
            aluOut   = rsVal & rtVal;
            regWe    = 1'b1;
            regWAddr = rd;
          end
          FN_OR: begin
            aluOut   = rsVal | rtVal;
            regWe    = 1'b1;
            regWAddr = rd;
          end
          FN_SLT: begin
            aluOut   = {31'd0, ($signed(rsVal) < $signed(rtVal))};
            regWe    = 1'b1;
            regWAddr = rd;
          end
          FN_SLL: begin
            aluOut   = rtVal << shamt;
            regWe    = 1'b1;
            regWAddr = rd;
          end
          FN_SRL: begin
            aluOut   = rtVal >> shamt;
            regWe    = 1'b1;
            regWAddr = rd;
          end
`ifdef JAL_JR_EN
          FN_JR: begin
            aluOut = rsVal;
            nextPc = rsVal;
          end
`endif
          default: begin
            aluOut = 32'd0;
          end
        endcase
      end
      OP_ADDI: begin
        aluOut   = rsVal + immSext;
        regWe    = 1'b1;
        regWAddr = rt;
      end
      OP_ANDI: begin
        aluOut   = rsVal & immZext;
        regWe    = 1'b1;
        regWAddr = rt;
      end
      OP_ORI: begin
        aluOut   = rsVal | immZext;
        regWe    = 1'b1;
        regWAddr = rt;
      end
      OP_LUI: begin
        aluOut   = {imm, 16'd0};
        regWe    = 1'b1;
        regWAddr = rt;
      end
      OP_LW: begin
        aluOut   = memAddr;
        regWe    = 1'b1;
        regWAddr = rt;
        isLoad   = 1'b1;
      end
      OP_SW: begin
        aluOut = memAddr;
        memWe  = 1'b1;
      end
      OP_BEQ: begin
        aluOut = rsVal - rtVal;
        if (rsVal == rtVal) begin
          nextPc = pcPlus4 + {immSext[29:0], 2'b00};
        end
      end
      OP_BNE: begin
        aluOut = rsVal - rtVal;
        if (rsVal != rtVal) begin
          nextPc = pcPlus4 + {immSext[29:0], 2'b00};
        end
      end
      OP_J: begin
        nextPc = {pcPlus4[31:28], target, 2'b00};
      end
`ifdef JAL_JR_EN
      OP_JAL: begin
        aluOut   = pcPlus4;
        regWe    = 1'b1;
        regWAddr = 5'd31;
        nextPc   = {pcPlus4[31:28], target, 2'b00};
      end
`endif
      default: begin
        aluOut = 32'd0;
      end
    endcase
    regWData = isLoad ? memRData : aluOut;
  end

  // Program counter; only the low bits that address instruction memory survive.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= 32'd0;
    end else begin
      pc <= nextPc & PC_MASK;
    end
  end

  // The ALU output of the executing instruction is visible externally.
  always_comb begin
    result = aluOut;
  end

endmodule

// File: tb/tb_ozer_alican_pr4.sv
// tb_ozer_alican_pr4: directed program with hand-derived values, then a
// randomized instruction stream checked against an instruction-level model.

module tb_ozer_alican_pr4;

  localparam int IMEM_WORDS  = 1024;
  localparam int DMEM_WORDS  = 1024;
  localparam int RAND_CYCLES = 400;

  logic        clock;
  logic        reset;
  logic [31:0] result;

  int totalCount = 0;
  int badCount   = 0;

  logic [31:0] mRegs [0:31];
  logic [31:0] mDmem [0:DMEM_WORDS-1];
  logic [31:0] mImem [0:IMEM_WORDS-1];
  logic [31:0] mPc;

  logic [31:0] dirPc [$];
  logic [31:0] dirRes [$];

  ozer_alican_pr4 #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .result (result)
  );

  initial begin
    clock = 1'b0;
    forever #25 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance the given number of rising edges, then park on the falling edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    int          k;
    rs  = 5'($urandom_range(0, 31));
    rt  = 5'($urandom_range(0, 31));
    rd  = 5'($urandom_range(0, 31));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = $urandom_range(0, 17);
    case (k)
      0:  return rType(rs, rt, rd, sh, 6'h20);
      1:  return rType(rs, rt, rd, sh, 6'h22);
      2:  return rType(rs, rt, rd, sh, 6'h24);
      3:  return rType(rs, rt, rd, sh, 6'h25);
      4:  return rType(rs, rt, rd, sh, 6'h2A);
      5:  return rType(rs, rt, rd, sh, 6'h00);
      6:  return rType(rs, rt, rd, sh, 6'h02);
      7:  return rType(rs, rt, rd, sh, 6'h08);
      8:  return rType(rs, rt, rd, sh, 6'($urandom));
      9:  return iType(6'h08, rs, rt, imm);
      10: return iType(6'h0C, rs, rt, imm);
      11: return iType(6'h0D, rs, rt, imm);
      12: return iType(6'h0F, rs, rt, imm);
      13: return iType(6'h23, rs, rt, imm);
      14: return iType(6'h2B, rs, rt, imm);
      15: return iType(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm);
      16: return iType(6'h05, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm);
      default: begin
        case ($urandom_range(0, 2))
          0:       return jType(6'h02, 26'($urandom));
          1:       return jType(6'h03, 26'($urandom));
          default: return $urandom;
        endcase
      end
    endcase
  endfunction

  // Instruction-level model: executes the instruction at mPc and commits it.
  task automatic modelStep(output logic [31:0] expRes);
    logic [31:0] ins;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rtIdx;
    logic [4:0]  rdIdx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sImm;
    logic [31:0] zImm;
    logic [31:0] pc4;
    logic [31:0] nxt;
    logic [31:0] addr;
    logic [31:0] wval;
    logic        wr;
    logic [4:0]  wreg;
    ins   = mImem[int'((mPc / 4) % IMEM_WORDS)];
    op    = ins[31:26];
    fn    = ins[5:0];
    rtIdx = ins[20:16];
    rdIdx = ins[15:11];
    a     = (ins[25:21] == 5'd0) ? 32'd0 : mRegs[ins[25:21]];
    b     = (rtIdx == 5'd0) ? 32'd0 : mRegs[rtIdx];
    sImm  = {{16{ins[15]}}, ins[15:0]};
    zImm  = {16'd0, ins[15:0]};
    pc4   = mPc + 32'd4;
    nxt   = pc4;
    addr  = a + sImm;
    expRes = 32'd0;
    wr    = 1'b0;
    wreg  = 5'd0;
    wval  = 32'd0;
    case (op)
      6'h00: begin
        wr   = 1'b1;
        wreg = rdIdx;
        case (fn)
          6'h20: expRes = a + b;
          6'h22: expRes = a - b;
          6'h24: expRes = a & b;
          6'h25: expRes = a | b;
          6'h2A: expRes = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: expRes = b << ins[10:6];
          6'h02: expRes = b >> ins[10:6];
`ifdef JAL_JR_EN
          6'h08: begin
            wr     = 1'b0;
            expRes = a;
            nxt    = a;
          end
`endif
          default: wr = 1'b0;
        endcase
        wval = expRes;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        wr   = 1'b1;
        wreg = rtIdx;
        if (op == 6'h08) expRes = a + sImm;
        else if (op == 6'h0C) expRes = a & zImm;
        else if (op == 6'h0D) expRes = a | zImm;
        else expRes = zImm * 65536;
        wval = expRes;
      end
      6'h23: begin
        expRes = addr;
        wr     = 1'b1;
        wreg   = rtIdx;
        wval   = mDmem[int'((addr / 4) % DMEM_WORDS)];
      end
      6'h2B: begin
        expRes = addr;
        mDmem[int'((addr / 4) % DMEM_WORDS)] = b;
      end
      6'h04: begin
        expRes = a - b;
        if (a == b) nxt = pc4 + sImm * 4;
      end
      6'h05: begin
        expRes = a - b;
        if (a != b) nxt = pc4 + sImm * 4;
      end
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
`ifdef JAL_JR_EN
      6'h03: begin
        expRes = pc4;
        wr     = 1'b1;
        wreg   = 5'd31;
        wval   = pc4;
        nxt    = {pc4[31:28], ins[25:0], 2'b00};
      end
`endif
      default: expRes = 32'd0;
    endcase
    if (wr && (wreg != 5'd0)) mRegs[wreg] = wval;
    mPc = nxt % (IMEM_WORDS * 4);
  endtask

  task automatic putInstr(input int byteAddr, input logic [31:0] word);
    dut.imModul.iMem[byteAddr / 4] = word;
  endtask

  initial begin
    logic [31:0] expRes;
    logic [31:0] curPc;
    logic [31:0] w;

    // ---------------- directed program ----------------
    reset = 1'b1;
    for (int i = 0; i < IMEM_WORDS; i++) dut.imModul.iMem[i] = 32'hFC00_0000;
    for (int i = 0; i < 32; i++) dut.regMod.rMem[i] = 32'd0;
    for (int i = 0; i < DMEM_WORDS; i++) dut.datamem.dMem[i] = 32'd0;
    dut.regMod.rMem[1] = 32'd5;
    dut.regMod.rMem[2] = 32'd7;

    putInstr(32'h000, rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    putInstr(32'h004, rType(5'd1, 5'd2, 5'd4, 5'd0, 6'h22));
    putInstr(32'h008, rType(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A));
    putInstr(32'h00C, rType(5'd0, 5'd1, 5'd6, 5'd4, 6'h00));
    putInstr(32'h010, iType(6'h04, 5'd1, 5'd1, 16'd2));
    putInstr(32'h014, iType(6'h08, 5'd0, 5'd11, 16'h0077));
    putInstr(32'h018, iType(6'h08, 5'd0, 5'd11, 16'h0055));
    putInstr(32'h01C, iType(6'h05, 5'd1, 5'd1, 16'd2));
    putInstr(32'h020, iType(6'h0D, 5'd0, 5'd7, 16'hFFFF));
    putInstr(32'h024, iType(6'h08, 5'd0, 5'd8, 16'hFFFF));
    putInstr(32'h028, rType(5'd1, 5'd2, 5'd0, 5'd0, 6'h20));
    putInstr(32'h02C, iType(6'h2B, 5'd0, 5'd3, 16'd8));
    putInstr(32'h030, iType(6'h23, 5'd0, 5'd9, 16'd8));
    putInstr(32'h034, 32'hFC00_0000);
    putInstr(32'h038, iType(6'h0F, 5'd0, 5'd12, 16'h1234));
    putInstr(32'h03C, rType(5'd7, 5'd8, 5'd13, 5'd0, 6'h24));
    putInstr(32'h040, rType(5'd0, 5'd8, 5'd14, 5'd28, 6'h02));
    putInstr(32'h044, jType(6'h02, 26'h40));
    putInstr(32'h100, iType(6'h0C, 5'd8, 5'd15, 16'h00F0));
    putInstr(32'h104, rType(5'd8, 5'd1, 5'd16, 5'd0, 6'h2A));
    putInstr(32'h108, jType(6'h03, 26'h80));
    putInstr(32'h10C, iType(6'h08, 5'd0, 5'd17, 16'd3));
    putInstr(32'h200, rType(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));

    dirPc  = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h01C, 32'h020, 32'h024,
               32'h028, 32'h02C, 32'h030, 32'h034, 32'h038, 32'h03C, 32'h040, 32'h044,
               32'h100, 32'h104, 32'h108};
    dirRes = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'h50, 32'd0, 32'd0, 32'h0000_FFFF, 32'hFFFF_FFFF,
               32'd12, 32'd8, 32'd8, 32'd0, 32'h1234_0000, 32'h0000_FFFF, 32'hF, 32'd0,
               32'hF0, 32'd1};
`ifdef JAL_JR_EN
    dirRes.push_back(32'h10C);
    dirPc.push_back(32'h200);
    dirRes.push_back(32'h10C);
`else
    dirRes.push_back(32'd0);
`endif
    dirPc.push_back(32'h10C);
    dirRes.push_back(32'd3);

    applyStimulus(2);
    checkOutput("reset_pc", dut.pc, 32'd0);
    checkOutput("reset_keep_r1", dut.regMod.rMem[1], 32'd5);
    checkOutput("reset_no_exec_r3", dut.regMod.rMem[3], 32'd0);
    reset = 1'b0;

    for (int i = 0; i < dirPc.size(); i++) begin
      checkOutput($sformatf("dir_pc%0d", i), dut.pc, dirPc[i]);
      checkOutput($sformatf("dir_res%0d", i), result, dirRes[i]);
      applyStimulus(1);
    end

    checkOutput("dir_final_pc", dut.pc, 32'h110);
    checkOutput("dir_r0", dut.regMod.rMem[0], 32'd0);
    checkOutput("dir_r3", dut.regMod.rMem[3], 32'd12);
    checkOutput("dir_r4", dut.regMod.rMem[4], 32'hFFFF_FFFE);
    checkOutput("dir_r5", dut.regMod.rMem[5], 32'd1);
    checkOutput("dir_r6", dut.regMod.rMem[6], 32'h50);
    checkOutput("dir_r7", dut.regMod.rMem[7], 32'h0000_FFFF);
    checkOutput("dir_r8", dut.regMod.rMem[8], 32'hFFFF_FFFF);
    checkOutput("dir_r9", dut.regMod.rMem[9], 32'd12);
    checkOutput("dir_r11_skipped", dut.regMod.rMem[11], 32'd0);
    checkOutput("dir_r12", dut.regMod.rMem[12], 32'h1234_0000);
    checkOutput("dir_r13", dut.regMod.rMem[13], 32'h0000_FFFF);
    checkOutput("dir_r14", dut.regMod.rMem[14], 32'hF);
    checkOutput("dir_r15", dut.regMod.rMem[15], 32'hF0);
    checkOutput("dir_r16", dut.regMod.rMem[16], 32'd1);
    checkOutput("dir_r17", dut.regMod.rMem[17], 32'd3);
`ifdef JAL_JR_EN
    checkOutput("dir_r31_link", dut.regMod.rMem[31], 32'h10C);
`else
    checkOutput("dir_r31_untouched", dut.regMod.rMem[31], 32'd0);
`endif
    checkOutput("dir_dmem2", dut.datamem.dMem[2], 32'd12);
    checkOutput("dir_dmem3", dut.datamem.dMem[3], 32'd0);

    // ---------------- randomized stream vs model ----------------
    reset = 1'b1;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      w = randInstr();
      mImem[i] = w;
      dut.imModul.iMem[i] = w;
    end
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if (i == 0) w = 32'hDEAD_BEEF;
      mRegs[i] = w;
      dut.regMod.rMem[i] = w;
    end
    for (int i = 0; i < DMEM_WORDS; i++) begin
      w = $urandom;
      mDmem[i] = w;
      dut.datamem.dMem[i] = w;
    end
    mPc = 32'd0;

    applyStimulus(2);
    reset = 1'b0;

    for (int c = 0; c < RAND_CYCLES; c++) begin
      curPc = mPc;
      modelStep(expRes);
      checkOutput($sformatf("rnd_pc%0d", c), dut.pc, curPc);
      checkOutput($sformatf("rnd_res%0d", c), result, expRes);
      applyStimulus(1);
    end

    checkOutput("rnd_final_pc", dut.pc, mPc);
    checkOutput("rnd_r0_storage", dut.regMod.rMem[0], 32'hDEAD_BEEF);
    for (int i = 1; i < 32; i++) begin
      checkOutput($sformatf("rnd_reg%0d", i), dut.regMod.rMem[i], mRegs[i]);
    end
    for (int i = 0; i < DMEM_WORDS; i++) begin
      checkOutput($sformatf("rnd_dmem%0d", i), dut.datamem.dMem[i], mDmem[i]);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
